// File: rtl/fetch_ifid_stage_if.sv
// Fetch-stage bus bundle: instruction memory handshake, hazard/redirect controls and the IF/ID outputs.
// The master side is the fetch stage; the slave side is memory, hazard unit, EX and ID.
interface fetch_ifid_stage_if #(
    parameter int unsigned PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ready;
    logic [31:0]     imem_rdata;
    logic            stall;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic [31:0]     ifid_instr;
    logic [PC_W-1:0] ifid_pc;
    logic            ifid_valid;

    modport master (
        output imem_req, imem_addr, ifid_instr, ifid_pc, ifid_valid,
        input  imem_ready, imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, ifid_instr, ifid_pc, ifid_valid,
        output imem_ready, imem_rdata, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_ifid_stage.sv
// Instruction fetch stage with IF/ID register: holds the PC, absorbs memory waits and stalls
// through a one-word skid buffer, and flushes to a NOP bubble on branch redirect.
module fetch_ifid_stage #(
    parameter int unsigned    PC_W      = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [31:0]    NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               reset,
    fetch_ifid_stage_if.master bus
);
    typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     buf_q, buf_d;
    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] ipc_q, ipc_d;
    logic            valid_q, valid_d;
    logic [PC_W-1:0] pc_inc;

    assign pc_inc = pc_q + PC_W'(4);

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            buf_q   <= '0;
            instr_q <= NOP_INSTR;
            ipc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
    end

    // Next state: redirect always returns to FETCH, even over a stall
    always_comb begin
        state_d = state_q;
        if (bus.redirect) begin
            state_d = FETCH;
        end else begin
            case (state_q)
                FETCH:   if (bus.imem_ready && bus.stall) state_d = HOLD;
                HOLD:    if (!bus.stall) state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end
    end

    // Datapath next values and registered outputs
    always_comb begin
        pc_d    = pc_q;
        buf_d   = buf_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        if (bus.redirect) begin
            pc_d    = bus.redirect_pc;
            instr_d = NOP_INSTR;
            ipc_d   = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (bus.imem_ready && !bus.stall) begin
                        instr_d = bus.imem_rdata;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_inc;
                    end else if (bus.imem_ready) begin
                        buf_d = bus.imem_rdata;
                    end else if (!bus.stall) begin
                        instr_d = NOP_INSTR;
                        ipc_d   = pc_q;
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!bus.stall) begin
                        instr_d = buf_q;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.imem_req   = (state_q == FETCH);
        bus.imem_addr  = pc_q;
        bus.ifid_instr = instr_q;
        bus.ifid_pc    = ipc_q;
        bus.ifid_valid = valid_q;
    end
endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Scoreboard bench for fetch_ifid_stage: directed cycles push the expected IF/ID word,
// a monitor pops and compares one entry after each clock edge.
module tb_fetch_ifid_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [7:0]  pc;
        logic        valid;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    exp_t sb[$];

    fetch_ifid_stage_if #(.PC_W(8)) bus ();

    fetch_ifid_stage #(.PC_W(8), .RESET_PC(8'h00), .NOP_INSTR(NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Instruction memory: each word encodes its own address
    assign bus.imem_rdata = 32'h0010_0093 + {24'h0, bus.imem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] w(input logic [7:0] a);
        return 32'h0010_0093 + {24'h0, a};
    endfunction

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs at the negedge, record the IF/ID value expected after the edge
    task automatic cyc(input logic rdy, input logic stl, input logic rdr, input logic [7:0] rpc,
                       input logic [31:0] e_instr, input logic [7:0] e_pc, input logic e_v);
        exp_t e;
        @(negedge clk);
        bus.imem_ready  = rdy;
        bus.stall       = stl;
        bus.redirect    = rdr;
        bus.redirect_pc = rpc;
        e.instr = e_instr;
        e.pc    = e_pc;
        e.valid = e_v;
        sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic chk_req(input string name, input logic req, input logic [7:0] addr);
        #1;
        chk({name, "_req"}, 40'(bus.imem_req), 40'(req));
        chk({name, "_addr"}, 40'(bus.imem_addr), 40'(addr));
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ifid_instr", 40'(bus.ifid_instr), 40'(e.instr));
                chk("ifid_pc", 40'(bus.ifid_pc), 40'(e.pc));
                chk("ifid_valid", 40'(bus.ifid_valid), 40'(e.valid));
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        total = 0;
        bad   = 0;
        bus.imem_ready  = 1'b0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 8'h00;
        reset = 1'b1;
        #12;
        chk("rst_instr", 40'(bus.ifid_instr), 40'(NOP));
        chk("rst_valid", 40'(bus.ifid_valid), 40'(0));
        chk("rst_pc", 40'(bus.ifid_pc), 40'(0));
        @(negedge clk);
        reset = 1'b0;
        chk_req("post_rst", 1'b1, 8'h00);

        // Streaming then two wait states at 0x08
        cyc(1, 0, 0, 8'h00, w(8'h00), 8'h00, 1);
        cyc(1, 0, 0, 8'h00, w(8'h04), 8'h04, 1);
        cyc(0, 0, 0, 8'h00, NOP,      8'h08, 0);
        cyc(0, 0, 0, 8'h00, NOP,      8'h08, 0);
        cyc(1, 0, 0, 8'h00, w(8'h08), 8'h08, 1);
        cyc(1, 0, 0, 8'h00, w(8'h0C), 8'h0C, 1);

        // Stall for 3 cycles while 0x10 returns
        cyc(1, 1, 0, 8'h00, w(8'h0C), 8'h0C, 1);
        chk_req("hold", 1'b0, 8'h10);
        cyc(1, 1, 0, 8'h00, w(8'h0C), 8'h0C, 1);
        cyc(0, 1, 0, 8'h00, w(8'h0C), 8'h0C, 1);
        chk_req("hold2", 1'b0, 8'h10);
        cyc(0, 0, 0, 8'h00, w(8'h10), 8'h10, 1);
        cyc(1, 0, 0, 8'h00, w(8'h14), 8'h14, 1);

        // Capture 0x18 into the buffer, then redirect over the stall
        cyc(1, 1, 0, 8'h00, w(8'h14), 8'h14, 1);
        cyc(1, 1, 1, 8'h40, NOP,      8'h00, 0);
        chk_req("redir", 1'b1, 8'h40);
        cyc(1, 0, 0, 8'h00, w(8'h40), 8'h40, 1);
        cyc(1, 0, 0, 8'h00, w(8'h44), 8'h44, 1);

        // PC wrap
        cyc(1, 0, 1, 8'hF8, NOP,      8'h00, 0);
        cyc(1, 0, 0, 8'h00, w(8'hF8), 8'hF8, 1);
        cyc(1, 0, 0, 8'h00, w(8'hFC), 8'hFC, 1);
        cyc(1, 0, 0, 8'h00, w(8'h00), 8'h00, 1);
        cyc(1, 0, 0, 8'h00, w(8'h04), 8'h04, 1);

        // Wait with stall holds IF/ID, then bubble, then the word
        cyc(0, 1, 0, 8'h00, w(8'h04), 8'h04, 1);
        cyc(0, 0, 0, 8'h00, NOP,      8'h08, 0);
        cyc(1, 0, 0, 8'h00, w(8'h08), 8'h08, 1);

        // Asynchronous reset in HOLD
        cyc(1, 1, 0, 8'h00, w(8'h08), 8'h08, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_instr", 40'(bus.ifid_instr), 40'(NOP));
        chk("arst_valid", 40'(bus.ifid_valid), 40'(0));
        chk("arst_pc", 40'(bus.ifid_pc), 40'(0));
        chk("arst_req", 40'(bus.imem_req), 40'(1));
        chk("arst_addr", 40'(bus.imem_addr), 40'(0));
        @(negedge clk);
        reset = 1'b0;
        cyc(1, 0, 0, 8'h00, w(8'h00), 8'h00, 1);
        cyc(1, 0, 0, 8'h00, w(8'h04), 8'h04, 1);

        @(negedge clk);
        chk("sb_drained", 40'(sb.size()), 40'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
